// File: rtl/r_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// r_bus_rr_arbiter
//
// Shares the single register-file read port among NUM_REQ read masters. The
// arbiter runs one transaction at a time. The grant is held until the
// downstream handshake completes or the watchdog aborts the read. Read data
// is broadcast on s_data, and only the granted master gets an s_ready strobe.
//
// Parameters
//   NUM_REQ   number of requesting masters (2..8)
//   TIMEOUT   maximum BUSY cycles without m_ready before abort (1..65535)
//   ERR_DATA  word returned to the master on an aborted read
//
// Ports
//   clk          clock
//   rstn         synchronous reset, active-low
//   s_valid      per-master read request
//   s_addr       per-master address; master i uses bits [8i+7:8i]
//   s_ready      per-master completion strobe, one-hot or zero
//   s_data       read data, meaningful only with the master's s_ready
//   m_valid      downstream read request
//   m_addr       downstream address
//   m_ready      downstream acceptance; m_data valid in the same cycle
//   m_data       downstream read data
//   grant_idx    index of the current or last granted master
//   busy         high while a transaction is outstanding
//   timeout_err  sticky abort flag, cleared only by reset
// ---------------------------------------------------------------------------
module r_bus_rr_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   s_valid,
  input  logic [NUM_REQ*8-1:0] s_addr,
  output logic [NUM_REQ-1:0]   s_ready,
  output logic [31:0]          s_data,
  output logic                 m_valid,
  output logic [7:0]           m_addr,
  input  logic                 m_ready,
  input  logic [31:0]          m_data,
  output logic [2:0]           grant_idx,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic {
    STT_IDLE,
    STT_BUSY
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'(NUM_REQ - 1);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state,       state_nxt;
  logic [2:0]  rr_ptr,      rr_ptr_nxt;
  logic [2:0]  grant_nxt;
  logic        m_valid_nxt;
  logic [7:0]  m_addr_nxt;
  logic [15:0] wait_cnt,    wait_cnt_nxt;
  logic        terr_nxt;

  logic        found_hi, found_lo;
  logic [2:0]  pick_hi,  pick_lo, pick;
  logic [7:0]  pick_addr;
  logic        at_limit, done, abort;

  // Round-robin search: the first requester at or above rr_ptr wins.
  // Otherwise the search wraps to the lowest-numbered requester.
  // NOTE: every variable written in an always_comb gets a default first.
  // A path that leaves one unassigned would infer a latch.
  always_comb begin
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    pick_hi   = '0;
    pick_lo   = '0;
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_valid[i] && (3'(i) >= rr_ptr) && !found_hi) begin
        found_hi = 1'b1;
        pick_hi  = 3'(i);
      end
      if (s_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = 3'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == 3'(i)) pick_addr = s_addr[8*i +: 8];
    end
  end

  // Completion happens on a handshake or on watchdog expiry. The handshake
  // has priority when both occur in the same cycle.
  assign busy     = (state == STT_BUSY);
  assign at_limit = (wait_cnt == CNT_LAST);
  assign done     = busy && (m_ready || at_limit);
  assign abort    = busy && !m_ready && at_limit;

  always_comb begin
    s_data = '0;
    if (done) s_data = m_ready ? m_data : ERR_DATA;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign s_ready[i] = done && (grant_idx == 3'(i));
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant_idx;
    m_valid_nxt  = m_valid;
    m_addr_nxt   = m_addr;
    wait_cnt_nxt = wait_cnt;
    terr_nxt     = timeout_err;
    case (state)
      STT_IDLE: begin
        if (found_lo) begin
          grant_nxt    = pick;
          m_addr_nxt   = pick_addr;
          m_valid_nxt  = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = STT_BUSY;
        end
      end
      STT_BUSY: begin
        if (done) begin
          m_valid_nxt = 1'b0;
          rr_ptr_nxt  = (grant_idx == LAST_IDX) ? 3'd0 : grant_idx + 3'd1;
          state_nxt   = STT_IDLE;
          if (abort) terr_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      default: state_nxt = STT_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so that every flop samples
  // pre-edge values regardless of statement order. Reset is synchronous and
  // is therefore not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= STT_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      m_valid     <= 1'b0;
      m_addr      <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant_idx   <= grant_nxt;
      m_valid     <= m_valid_nxt;
      m_addr      <= m_addr_nxt;
      wait_cnt    <= wait_cnt_nxt;
      timeout_err <= terr_nxt;
    end
  end

endmodule

// File: tb/tb_r_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_r_bus_rr_arbiter
//
// Self-checking bench for r_bus_rr_arbiter with NUM_REQ=4 and TIMEOUT=16.
// Each scenario pushes the completions it expects (master, data) into a
// queue. The monitor pops and compares an entry on every s_ready pulse.
// A slave model answers m_valid after a programmable number of wait
// states, or it stalls.
// ---------------------------------------------------------------------------
module tb_r_bus_rr_arbiter;

  localparam int          NUM_REQ = 4;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NUM_REQ-1:0]   s_valid;
  logic [NUM_REQ*8-1:0] s_addr;
  logic [NUM_REQ-1:0]   s_ready;
  logic [31:0]          s_data;
  logic                 m_valid;
  logic [7:0]           m_addr;
  logic                 m_ready;
  logic [31:0]          m_data;
  logic [2:0]           grant_idx;
  logic                 busy;
  logic                 timeout_err;

  r_bus_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT),
    .ERR_DATA(ERR)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_addr     (m_addr),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   done_cycles[$];
  int   checks      = 0;
  int   failures    = 0;
  int   cycle       = 0;
  int   req_left[NUM_REQ];
  int   wait_states = 0;
  bit   stall       = 1'b0;
  int   slv_cnt     = 0;
  bit   done_now    = 1'b0;

  function automatic logic [31:0] slave_word(input logic [7:0] a);
    return 32'h0000_1224 + {24'h0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  task automatic refresh_valid();
    for (int i = 0; i < NUM_REQ; i++) s_valid[i] = (req_left[i] != 0);
  endtask

  task automatic request(input int m, input logic [7:0] a, input int n);
    s_addr[8*m +: 8] = a;
    req_left[m] += n;
    refresh_valid();
  endtask

  task automatic expect_rd(input int m, input logic [31:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // One clock cycle. The slave drives at the falling edge, and the monitor
  // samples 1 time unit later, well away from the rising edge.
  task automatic tick();
    exp_t       e;
    logic [3:0] oh;
    @(negedge clk);
    cycle++;
    if (m_valid && !stall) begin
      if (slv_cnt >= wait_states) begin
        m_ready = 1'b1;
        m_data  = slave_word(m_addr);
      end else begin
        m_ready = 1'b0;
        m_data  = 32'hBAD0_0000 | 32'(slv_cnt);
      end
      slv_cnt++;
    end else begin
      m_ready = 1'b0;
      m_data  = 32'hBAD0_0000 | 32'(slv_cnt);
      if (!m_valid) slv_cnt = 0;
    end
    #1;
    done_now = 1'b0;
    if (s_ready != '0) begin
      done_now = 1'b1;
      done_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(s_ready), 32'h0);
      end else begin
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.m;
        check("ready_onehot", 32'(s_ready), 32'(oh));
        check("read_data", s_data, e.d);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (s_ready[i] && req_left[i] > 0) req_left[i]--;
      refresh_valid();
    end else begin
      check("idle_data_zero", s_data, 32'h0);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_budget", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      for (int i = 0; i < NUM_REQ; i++) req_left[i] = 0;
      refresh_valid();
    end
  endtask

  initial begin
    int n;
    rstn    = 1'b0;
    s_addr  = '0;
    m_ready = 1'b0;
    m_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) req_left[i] = 0;
    refresh_valid();

    // Reset state
    repeat (2) tick();
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_addr", 32'(m_addr), 32'h0);
    check("rst_grant", 32'(grant_idx), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);
    rstn = 1'b1;
    tick();

    // Round robin from rr_ptr=0 with all masters requesting continuously
    request(0, 8'h40, 2);
    request(1, 8'h41, 2);
    request(2, 8'h42, 1);
    request(3, 8'h43, 1);
    expect_rd(0, slave_word(8'h40));
    expect_rd(1, slave_word(8'h41));
    expect_rd(2, slave_word(8'h42));
    expect_rd(3, slave_word(8'h43));
    expect_rd(0, slave_word(8'h40));
    expect_rd(1, slave_word(8'h41));
    done_cycles.delete();
    drain(40);
    check("rr_count", 32'(done_cycles.size()), 32'd6);
    for (int i = 1; i < done_cycles.size(); i++)
      check("rr_gap", 32'(done_cycles[i] - done_cycles[i-1]), 32'd2);
    tick();

    // Single zero-wait request from master 2 (rr_ptr is now 2)
    request(2, 8'h10, 1);
    check("single_pre_valid", 32'(m_valid), 32'h0);
    expect_rd(2, 32'h0000_1234);
    tick();
    check("single_m_valid", 32'(m_valid), 32'h1);
    check("single_m_addr", 32'(m_addr), 32'h10);
    check("single_busy", 32'(busy), 32'h1);
    check("single_grant", 32'(grant_idx), 32'd2);
    check("single_done", 32'(done_now), 32'h1);
    tick();
    check("single_busy_end", 32'(busy), 32'h0);
    check("single_valid_end", 32'(m_valid), 32'h0);
    drain(4);

    // Fairness after wrap: rr_ptr=3, masters 1 and 3 -> 3 first
    request(1, 8'h21, 1);
    request(3, 8'h23, 1);
    expect_rd(3, slave_word(8'h23));
    expect_rd(1, slave_word(8'h21));
    drain(20);
    // rr_ptr is 2 now, so master 2 must beat master 0
    request(0, 8'h30, 1);
    request(2, 8'h32, 1);
    expect_rd(2, slave_word(8'h32));
    expect_rd(0, slave_word(8'h30));
    drain(20);
    tick();

    // Wait states: ready on the 6th BUSY cycle, address held stable
    wait_states = 5;
    request(1, 8'h33, 1);
    expect_rd(1, slave_word(8'h33));
    n = 0;
    for (int k = 0; k < 30 && !done_now; k++) begin
      tick();
      if (busy) begin
        n++;
        check("ws_m_addr", 32'(m_addr), 32'h33);
        check("ws_m_valid", 32'(m_valid), 32'h1);
      end
    end
    check("ws_busy_cycles", 32'(n), 32'd6);
    repeat (3) tick();
    check("ws_terr", 32'(timeout_err), 32'h0);
    drain(4);
    wait_states = 0;

    // Timeout: rr_ptr=2, masters 3 and 0 request, slave stalls
    stall = 1'b1;
    request(3, 8'h53, 1);
    request(0, 8'h50, 1);
    expect_rd(3, ERR);
    expect_rd(0, slave_word(8'h50));
    n = 0;
    done_now = 1'b0;
    for (int k = 0; k < 40 && !done_now; k++) begin
      tick();
      if (busy) n++;
    end
    check("to_busy_cycles", 32'(n), 32'd16);
    check("to_grant", 32'(grant_idx), 32'd3);
    stall = 1'b0;
    tick();
    check("to_terr_set", 32'(timeout_err), 32'h1);
    drain(20);
    check("to_next_grant", 32'(grant_idx), 32'd0);
    check("to_terr_sticky", 32'(timeout_err), 32'h1);
    tick();

    // Reset in the middle of a stalled read
    stall = 1'b1;
    request(1, 8'h61, 1);
    repeat (4) tick();
    check("rb_busy_before", 32'(busy), 32'h1);
    rstn = 1'b0;
    req_left[1] = 0;
    refresh_valid();
    tick();
    rstn  = 1'b1;
    stall = 1'b0;
    check("rb_m_valid", 32'(m_valid), 32'h0);
    check("rb_busy", 32'(busy), 32'h0);
    check("rb_terr", 32'(timeout_err), 32'h0);
    check("rb_grant", 32'(grant_idx), 32'h0);
    check("rb_no_ready", 32'(done_now), 32'h0);
    tick();
    // rr_ptr must be 0 again, so master 0 goes before master 2
    request(0, 8'h70, 1);
    request(2, 8'h72, 1);
    expect_rd(0, slave_word(8'h70));
    expect_rd(2, slave_word(8'h72));
    drain(20);

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r_bus_rr_arbiter.md
Name: r_bus_rr_arbiter

Overview:
- Round-robin arbiter that shares the single register-file read port (addr/valid/ready/data handshake) among NUM_REQ read masters, such as the parameter readers of the left and right motor controllers and the odometry logger.
- It accepts one transaction at a time and locks the grant until the downstream handshake completes. The returned data is routed to the granted master only.
- A watchdog aborts a stalled read so that one unresponsive slave cannot deadlock every requester.

Parameters:
- NUM_REQ, 4, number of requesting masters (2..8).
- TIMEOUT, 1024, maximum cycles m_valid may stay high without m_ready before abort (1..65535).
- ERR_DATA, 32'hDEAD_BEEF, data word returned to a master on an aborted read.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, active-low.
- s_valid  in  NUM_REQ  per-master read request.
- s_addr  in  NUM_REQ*8  per-master address; master i uses bits [8i+7:8i].
- s_ready  out  NUM_REQ  per-master completion strobe; one-hot or zero.
- s_data  out  32  read data, broadcast to all masters; valid only with that master's s_ready.
- m_valid  out  1  downstream read request.
- m_addr  out  8  downstream address.
- m_ready  in  1  downstream acceptance; m_data is valid in the same cycle.
- m_data  in  32  downstream read data.
- grant_idx  out  3  index of the current or last granted master.
- busy  out  1  high while in STT_BUSY.
- timeout_err  out  1  sticky flag, set on any abort, cleared only by reset.

Behaviour:
- Reset values: state STT_IDLE, rr_ptr 0, m_valid 0, m_addr 0, grant_idx 0, timeout_err 0, wait counter 0.
- s_ready is 0 and s_data is 0 whenever no completion occurs.
- STT_IDLE:
  - If any s_valid is high, grant the first asserted index searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On grant, register grant_idx, set m_addr to the granted master's s_addr, set m_valid to 1, clear the wait counter, and go to STT_BUSY.
  - Requests are decided in the cycle they are sampled; m_valid rises on the next edge.
- STT_BUSY:
  - m_valid is held at 1 and m_addr is held stable.
  - The handshake occurs when m_valid and m_ready are both high. In that same cycle (combinational): s_ready[grant_idx] is 1 and s_data equals m_data.
  - On the edge after the handshake: m_valid goes to 0, rr_ptr becomes (grant_idx+1) mod NUM_REQ, and the state returns to STT_IDLE.
  - The wait counter increments each BUSY cycle without m_ready.
  - If the counter reaches TIMEOUT-1 with m_ready still low, abort in that cycle: s_ready[grant_idx] is 1, s_data is ERR_DATA, and timeout_err is set. On the next edge: m_valid goes to 0, rr_ptr advances, and the state returns to STT_IDLE.
  - If m_ready and the timeout condition coincide, the handshake wins: real data is returned and timeout_err is not set.
- Minimum occupancy is 2 cycles (grant cycle plus one BUSY cycle). A new grant is possible in the first IDLE cycle after completion, so back-to-back throughput is one read per 2 cycles.
- Masters must hold s_valid and s_addr stable until their own s_ready. If the granted master drops s_valid mid-transaction, the read still completes on the downstream port and the s_ready pulse is issued anyway; the master ignores it.
- A master whose s_ready fires in cycle t may re-assert s_valid in cycle t+1. Because rr_ptr has moved past it, every other pending master is served before it again (starvation-free). A master waits at most NUM_REQ-1 other transactions.
- Reset asserted mid-transaction: m_valid drops on that edge and no s_ready is issued. The downstream slave must tolerate the withdrawal.
- grant_idx width is fixed at 3 bits; unused upper bits are 0.

Test Plan:
- Single request: master 2 requests addr 8'h10 with 0 wait states (m_ready tied high, m_data 32'h0000_1234) -> m_valid/m_addr 8'h10 one cycle after the request; s_ready 4'b0100 with s_data 32'h0000_1234 in the next cycle; busy high for exactly 1 cycle.
- Round robin: all 4 masters hold s_valid continuously -> grant order 0,1,2,3,0,1; each s_ready pulse is 1 cycle wide; one completion every 2 cycles.
- Fairness after wrap: rr_ptr=3, requests from masters 1 and 3 -> master 3 is served first, then master 1; rr_ptr ends at 2.
- Wait states: slave asserts m_ready after 5 cycles -> m_addr is stable throughout; exactly one s_ready pulse carrying the data from that cycle; timeout_err stays 0.
- Timeout: TIMEOUT=16, m_ready held low -> s_ready to the granted master on the 16th BUSY cycle with s_data 32'hDEAD_BEEF; timeout_err=1 and stays 1; the next master is granted afterward.
- Reset mid-BUSY: rstn low for 1 cycle during the wait -> m_valid 0, no s_ready, rr_ptr 0, timeout_err 0; after release, normal arbitration resumes from master 0.
